// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the CPU: register tag layout, the
// "register file" forwarding select value and the select-width helper.
package cpu_pipe_pkg;

    localparam int REG_AW     = 5;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic              v;
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } tag_t;

    function automatic int selW(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the CPU pipeline control and the forwarding/hazard unit.
// The master is the pipeline side, the slave is the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
);
    logic                      ex_valid_i;
    logic                      ex_regwrite_i;
    logic [REG_AW-1:0]         ex_rd_i;
    logic                      ex_is_load_i;
    logic [NUM_SRC*REG_AW-1:0] ex_rs_i;
    logic [NUM_SRC-1:0]        ex_rs_used_i;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [NUM_SRC-1:0]        id_rs_used_i;
    logic                      flush_i;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
    logic                      stall_o;
    logic                      err_o;
    logic [CNT_W-1:0]          stall_cnt_o;

    modport master (
        output ex_valid_i, ex_regwrite_i, ex_rd_i, ex_is_load_i,
        output ex_rs_i, ex_rs_used_i, id_rs_i, id_rs_used_i, flush_i,
        input  fwd_sel_o, stall_o, err_o, stall_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_regwrite_i, ex_rd_i, ex_is_load_i,
        input  ex_rs_i, ex_rs_used_i, id_rs_i, id_rs_used_i, flush_i,
        output fwd_sel_o, stall_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_src_match.sv
// Priority comparator for one EX source operand across the tag stages.
// The nearest matching stage wins; hitLoad flags a win by a stage-1 load.
module fwd_src_match
    import cpu_pipe_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int REG_AW   = 5,
    parameter int SEL_W    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [DEPTH:1]             tagV,
    input  logic [DEPTH:1]             tagWr,
    input  logic [DEPTH:1][REG_AW-1:0] tagRd,
    input  logic [DEPTH:1]             tagLd,
    input  logic [REG_AW-1:0]          src,
    input  logic                       used,
    output logic [SEL_W-1:0]           sel,
    output logic                       hitLoad
);

    // Scan from the farthest stage inward so the nearest match overwrites.
    always_comb begin
        sel     = SEL_W'(FWD_SEL_RF);
        hitLoad = 1'b0;
        for (int s = DEPTH; s >= 1; s--) begin
            if (tagV[s] && tagWr[s] && used && (tagRd[s] == src) &&
                ((ZERO_REG == 0) || (tagRd[s] != '0))) begin
                sel     = SEL_W'(s);
                hitLoad = (s == 1) && tagLd[s];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadow tag pipeline past EX, per-source
// bypass selects, the ID-stage load-use stall, a sticky error and a stall counter.
module fwd_hazard_unit
    import cpu_pipe_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    fwd_hazard_unit_if.slave bus
);

    localparam int SEL_W = selW(DEPTH);

    logic [DEPTH:1]             tagV;
    logic [DEPTH:1]             tagWr;
    logic [DEPTH:1]             tagLd;
    logic [DEPTH:1][REG_AW-1:0] tagRd;
    logic [NUM_SRC-1:0]         hitLoad;
    logic [NUM_SRC*SEL_W-1:0]   selVec;
    logic                       idHit;
    logic                       stall;
    logic                       errFlag;
    logic [CNT_W-1:0]           stallCnt;

    // A flushed or bubble EX instruction enters stage 1 as an invalid tag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tagV  <= '0;
            tagWr <= '0;
            tagLd <= '0;
            tagRd <= '0;
        end else begin
            tagV[1]  <= bus.ex_valid_i & bus.ex_regwrite_i & ~bus.flush_i;
            tagWr[1] <= bus.ex_regwrite_i;
            tagRd[1] <= bus.ex_rd_i;
            tagLd[1] <= bus.ex_is_load_i;
            for (int s = 2; s <= DEPTH; s++) begin
                tagV[s]  <= tagV[s-1];
                tagWr[s] <= tagWr[s-1];
                tagRd[s] <= tagRd[s-1];
                tagLd[s] <= tagLd[s-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : gSrc
        fwd_src_match #(
            .DEPTH   (DEPTH),
            .REG_AW  (REG_AW),
            .SEL_W   (SEL_W),
            .ZERO_REG(ZERO_REG)
        ) uMatch (
            .tagV   (tagV),
            .tagWr  (tagWr),
            .tagRd  (tagRd),
            .tagLd  (tagLd),
            .src    (bus.ex_rs_i[k*REG_AW +: REG_AW]),
            .used   (bus.ex_rs_used_i[k]),
            .sel    (selVec[k*SEL_W +: SEL_W]),
            .hitLoad(hitLoad[k])
        );
    end

    // Load-use: the load in EX produces a register the ID instruction reads.
    always_comb begin
        idHit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.id_rs_used_i[k] && (bus.id_rs_i[k*REG_AW +: REG_AW] == bus.ex_rd_i) &&
                ((ZERO_REG == 0) || (bus.ex_rd_i != '0))) begin
                idHit = 1'b1;
            end
        end
        stall = bus.ex_valid_i & bus.ex_is_load_i & bus.ex_regwrite_i &
                ~bus.flush_i & ~rst_i & idHit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            errFlag  <= 1'b0;
            stallCnt <= '0;
        end else begin
            if (|hitLoad) begin
                errFlag <= 1'b1;
            end
            if (stall && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    assign bus.fwd_sel_o   = selVec;
    assign bus.stall_o     = stall;
    assign bus.err_o       = errFlag;
    assign bus.stall_cnt_o = stallCnt;

endmodule
